// File: rtl/ncc_wb_pkg.sv
// Shared types for the NCC result write-back path.
package ncc_wb_pkg;
  localparam int WORDS_PER_SET = 3;

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, FDONE} wb_state_t;

  typedef struct packed {
    logic [8:0]  idx;
    logic [63:0] ncc;
  } ncc_result_t;
endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO of NCC results; a pop in the same cycle frees a slot
// for a push even when full.
module result_fifo
  import ncc_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  ncc_result_t wdata,
  input  logic        pop,
  output ncc_result_t rdata,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  ncc_result_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ncc_result_writer.sv
// Buffers one best-match result per set and writes it to memory as a
// 3-word record, pulsing frame_done after the last set of a frame.
module ncc_result_writer
  import ncc_wb_pkg::*;
#(
  parameter int              NUM_SETS   = 150,
  parameter int              FIFO_DEPTH = 4,
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [63:0]       greatestNCCLog2,
  input  logic [8:0]        greatestWindowIndex,
  output logic              result_ready,
  output logic              req,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow
);
  wb_state_t   state_q, state_d;
  logic [7:0]  set_idx_q, set_idx_d;
  ncc_result_t rec_q, rec_d;
  logic        overflow_q, overflow_d;
  logic [1:0]  word_sel;

  ncc_result_t fifo_wdata, fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;

  assign fifo_wdata.idx = greatestWindowIndex;
  assign fifo_wdata.ncc = greatestNCCLog2;
  assign fifo_pop       = (state_q == IDLE) && !fifo_empty;

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (result_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign result_ready = !fifo_full;
  // A full FIFO still accepts when the head is leaving this cycle.
  assign overflow_d   = overflow_q | (result_valid && fifo_full && !fifo_pop);
  assign overflow     = overflow_q;

  always_comb begin
    state_d    = state_q;
    set_idx_d  = set_idx_q;
    rec_d      = rec_q;
    req        = 1'b0;
    frame_done = 1'b0;
    word_sel   = 2'd0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rec_d   = fifo_rdata;
          state_d = WR0;
        end
      end
      WR0: begin
        req = 1'b1;
        if (mem_ack) state_d = WR1;
      end
      WR1: begin
        req      = 1'b1;
        word_sel = 2'd1;
        if (mem_ack) state_d = WR2;
      end
      WR2: begin
        req      = 1'b1;
        word_sel = 2'd2;
        if (mem_ack) begin
          if (set_idx_q == 8'(NUM_SETS - 1)) begin
            set_idx_d = '0;
            state_d   = FDONE;
          end else begin
            set_idx_d = set_idx_q + 8'd1;
            state_d   = IDLE;
          end
        end
      end
      FDONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_wr = req;
  assign addr  = BASE_ADDR + ADDR_W'(set_idx_q) * ADDR_W'(WORDS_PER_SET) + ADDR_W'(word_sel);

  always_comb begin
    write_data = {set_idx_q, 15'b0, rec_q.idx};
    case (word_sel)
      2'd1:    write_data = rec_q.ncc[63:32];
      2'd2:    write_data = rec_q.ncc[31:0];
      default: write_data = {set_idx_q, 15'b0, rec_q.idx};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      set_idx_q  <= '0;
      rec_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_idx_q  <= set_idx_d;
      rec_q      <= rec_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
